// File: rtl/acc_core_p.sv
// -----------------------------------------------------------------------------
// acc_core_p -- parametrised two-phase accumulator processor core.
//
// Every instruction takes two cycles: FETCH latches {opcode, operand} from the
// program ROM and advances pc; EXEC carries out the instruction. Two-word
// instructions find their low address word on rom_data during EXEC, which
// forms the target/data address T = {ir_operand, rom_data}.
//
// Optional feature macro: ACC_CORE_CALL_EN
//   defined   : hardware return-address stack, CALL/RET, sticky stack fault
//   undefined : 0xE is a two-word NOP, 0xF a one-word NOP, sp/fault tied to 0
//
// Parameters
//   DW          data / accumulator / operand width (IW = 4+DW, AW = 2*DW+4)
//   STACK_DEPTH return-stack entries (>= 1)
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   rom_addr / rom_data    program address (= pc) / combinational program word
//   ram_addr               data address {ir_operand, rom_data}
//   ram_rdata / ram_wdata  combinational read data / write data (= acc)
//   ram_we / ram_re        single-cycle strobes during EXEC
//   in_port / out_port     input switches / registered output
//   pc, ir_opcode, ir_operand, acc, c_flag, z_flag   architectural state
//   phase                  0 = FETCH (or FAULT), 1 = EXEC
//   fault                  sticky stack overflow/underflow
//   sp                     return-stack entry count
// -----------------------------------------------------------------------------
module acc_core_p #(
  parameter int DW          = 4,
  parameter int STACK_DEPTH = 4,
  localparam int IW         = 4 + DW,
  localparam int AW         = 2 * DW + 4,
  localparam int SPW        = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [AW-1:0]  rom_addr,
  input  logic [IW-1:0]  rom_data,
  output logic [AW-1:0]  ram_addr,
  input  logic [DW-1:0]  ram_rdata,
  output logic [DW-1:0]  ram_wdata,
  output logic           ram_we,
  output logic           ram_re,
  input  logic [DW-1:0]  in_port,
  output logic [DW-1:0]  out_port,
  output logic [AW-1:0]  pc,
  output logic [3:0]     ir_opcode,
  output logic [DW-1:0]  ir_operand,
  output logic [DW-1:0]  acc,
  output logic           c_flag,
  output logic           z_flag,
  output logic           phase,
  output logic           fault,
  output logic [SPW-1:0] sp
);

  localparam logic [3:0] OP_JC   = 4'h0;
  localparam logic [3:0] OP_JNC  = 4'h1;
  localparam logic [3:0] OP_CMPI = 4'h2;
  localparam logic [3:0] OP_CMPM = 4'h3;
  localparam logic [3:0] OP_LIT  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JNZ  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_ADDM = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  localparam logic [AW-1:0] PC_ONE = AW'(1);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_FAULT} state_t;

  // DW+1-bit sum: top bit is the carry out.
  function automatic logic [DW:0] add_w(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // DW+1-bit difference: top bit is the borrow (a < b unsigned).
  function automatic logic [DW:0] sub_w(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic is_zero(input logic [DW-1:0] v);
    return (v == '0);
  endfunction

  // Instructions that carry an address low word in the following ROM slot.
  function automatic logic is_two_word(input logic [3:0] op);
    return !((op == OP_CMPI) || (op == OP_LIT) || (op == OP_IN) ||
             (op == OP_ADDI) || (op == OP_OUT) || (op == OP_RET));
  endfunction

  state_t         state, state_n;
  logic [AW-1:0]  pc_n, pc_inc, tgt;
  logic [3:0]     op_n;
  logic [DW-1:0]  opd_n, acc_n, out_n, alu_b;
  logic           c_n, z_n;
  logic [DW:0]    sum, diff;
  logic           in_exec;

  assign in_exec   = (state == S_EXEC);
  assign pc_inc    = pc + PC_ONE;
  assign tgt       = {ir_operand, rom_data};
  assign rom_addr  = pc;
  assign ram_addr  = tgt;
  assign ram_wdata = acc;
  assign phase     = in_exec;
  // Strobes decode straight from state, so an asynchronous reset drops them at once.
  assign ram_we    = in_exec && (ir_opcode == OP_ST);
  assign ram_re    = in_exec && ((ir_opcode == OP_LD) || (ir_opcode == OP_CMPM) ||
                                 (ir_opcode == OP_ADDM));
  assign alu_b     = ((ir_opcode == OP_CMPM) || (ir_opcode == OP_ADDM)) ? ram_rdata : ir_operand;
  assign sum       = add_w(acc, alu_b);
  assign diff      = sub_w(acc, alu_b);

`ifdef ACC_CORE_CALL_EN
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  logic [AW-1:0]  stack [STACK_DEPTH];
  logic [SPW-1:0] sp_r, sp_n, sp_dec;
  logic           fault_r, fault_n, push;

  assign sp_dec = sp_r - SP_ONE;
  assign sp     = sp_r;
  assign fault  = fault_r;

  // Stack storage carries no reset; only sp says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack[sp_r[SIW-1:0]] <= pc_inc;
  end
`else
  assign sp    = '0;
  assign fault = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    op_n    = ir_opcode;
    opd_n   = ir_operand;
    acc_n   = acc;
    c_n     = c_flag;
    z_n     = z_flag;
    out_n   = out_port;
`ifdef ACC_CORE_CALL_EN
    sp_n    = sp_r;
    fault_n = fault_r;
    push    = 1'b0;
`endif
    case (state)
      // ---- FETCH: latch instruction, step past it ----
      S_FETCH: begin
        {op_n, opd_n} = rom_data;
        pc_n          = pc_inc;
        state_n       = S_EXEC;
      end
      // ---- EXEC: execute; two-word ops also consume the address word ----
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = is_two_word(ir_opcode) ? pc_inc : pc;
        case (ir_opcode)
          OP_JC:   if (c_flag)  pc_n = tgt;
          OP_JNC:  if (!c_flag) pc_n = tgt;
          OP_JZ:   if (z_flag)  pc_n = tgt;
          OP_JNZ:  if (!z_flag) pc_n = tgt;
          OP_JMP:  pc_n = tgt;
          OP_CMPI, OP_CMPM: begin
            // Low DW bits of the difference are zero exactly when acc == operand.
            c_n = diff[DW];
            z_n = is_zero(diff[DW-1:0]);
          end
          OP_LIT: begin
            acc_n = ir_operand;
            z_n   = is_zero(ir_operand);
          end
          OP_IN: begin
            acc_n = in_port;
            z_n   = is_zero(in_port);
          end
          OP_LD: begin
            acc_n = ram_rdata;
            z_n   = is_zero(ram_rdata);
          end
          OP_ADDI, OP_ADDM: begin
            {c_n, acc_n} = sum;
            z_n          = is_zero(sum[DW-1:0]);
          end
          OP_OUT:  out_n = acc;
          OP_CALL: begin
`ifdef ACC_CORE_CALL_EN
            if (sp_r == SP_FULL) begin
              pc_n    = pc;
              fault_n = 1'b1;
              state_n = S_FAULT;
            end else begin
              push = 1'b1;
              sp_n = sp_r + SP_ONE;
              pc_n = tgt;
            end
`endif
          end
          OP_RET: begin
`ifdef ACC_CORE_CALL_EN
            if (sp_r == '0) begin
              fault_n = 1'b1;
              state_n = S_FAULT;
            end else begin
              sp_n = sp_dec;
              pc_n = stack[sp_dec[SIW-1:0]];
            end
`endif
          end
          default: ;
        endcase
      end
      // ---- FAULT: everything frozen until reset ----
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir_opcode  <= '0;
      ir_operand <= '0;
      acc        <= '0;
      c_flag     <= 1'b0;
      z_flag     <= 1'b0;
      out_port   <= '0;
`ifdef ACC_CORE_CALL_EN
      sp_r       <= '0;
      fault_r    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ir_opcode  <= op_n;
      ir_operand <= opd_n;
      acc        <= acc_n;
      c_flag     <= c_n;
      z_flag     <= z_n;
      out_port   <= out_n;
`ifdef ACC_CORE_CALL_EN
      sp_r       <= sp_n;
      fault_r    <= fault_n;
`endif
    end
  end

endmodule

// File: tb/tb_acc_core_p.sv
// -----------------------------------------------------------------------------
// tb_acc_core_p -- self-checking bench for acc_core_p (DW=4, STACK_DEPTH=4).
// A table of single instructions is placed at the expected pc one at a time,
// executed for exactly two cycles and compared against hand-computed results;
// hand-written sequences cover strobes, mid-EXEC reset and stack faults.
// -----------------------------------------------------------------------------
module tb_acc_core_p;

  logic        clk, rst;
  logic [11:0] rom_addr, ram_addr, pc;
  logic [7:0]  rom_data;
  logic [3:0]  ram_rdata, ram_wdata, in_port, out_port, ir_opcode, ir_operand, acc;
  logic        ram_we, ram_re, c_flag, z_flag, phase, fault;
  logic [2:0]  sp;

  logic [7:0]  rom [4096];
  logic [3:0]  ram [4096];

  int checks = 0;
  int errors = 0;

  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [11:0] we_addr;
  logic [3:0]  we_data;

  logic [11:0] cur_pc;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  opd;
    logic [7:0]  lo;
    logic [3:0]  inp;
    logic [3:0]  e_acc;
    logic        e_c;
    logic        e_z;
    logic [11:0] e_pc;
    logic [3:0]  e_out;
    logic [2:0]  e_sp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  acc_core_p #(.DW(4), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re),
    .in_port(in_port), .out_port(out_port),
    .pc(pc), .ir_opcode(ir_opcode), .ir_operand(ir_operand),
    .acc(acc), .c_flag(c_flag), .z_flag(z_flag),
    .phase(phase), .fault(fault), .sp(sp)
  );

  assign rom_data  = rom[rom_addr];
  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we) begin
      if (we_cnt == 0) begin
        we_addr <= ram_addr;
        we_data <= ram_wdata;
      end
      we_cnt <= we_cnt + 1;
    end
    if (ram_re) re_cnt <= re_cnt + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int op, input int opd, input int lo, input int inp,
                     input int a, input int c, input int z, input int p,
                     input int o, input int s, input string nm);
    vec_t v;
    v.op = 4'(op); v.opd = 4'(opd); v.lo = 8'(lo); v.inp = 4'(inp);
    v.e_acc = 4'(a); v.e_c = 1'(c); v.e_z = 1'(z); v.e_pc = 12'(p);
    v.e_out = 4'(o); v.e_sp = 3'(s); v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [11:0] nxt;
    nxt = cur_pc + 12'd1;
    rom[cur_pc] = {v.op, v.opd};
    rom[nxt]    = v.lo;
    in_port     = v.inp;
    step();
    chk({v.name, " phase"}, 32'(phase), 32'd1);
    step();
    chk({v.name, " acc"},   32'(acc),      32'(v.e_acc));
    chk({v.name, " c"},     32'(c_flag),   32'(v.e_c));
    chk({v.name, " z"},     32'(z_flag),   32'(v.e_z));
    chk({v.name, " pc"},    32'(pc),       32'(v.e_pc));
    chk({v.name, " out"},   32'(out_port), 32'(v.e_out));
    chk({v.name, " sp"},    32'(sp),       32'(v.e_sp));
    chk({v.name, " fault"}, 32'(fault),    32'd0);
    cur_pc = v.e_pc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " pc"},    32'(pc),         32'd0);
    chk({tag, " acc"},   32'(acc),        32'd0);
    chk({tag, " c"},     32'(c_flag),     32'd0);
    chk({tag, " z"},     32'(z_flag),     32'd0);
    chk({tag, " out"},   32'(out_port),   32'd0);
    chk({tag, " sp"},    32'(sp),         32'd0);
    chk({tag, " fault"}, 32'(fault),      32'd0);
    chk({tag, " phase"}, 32'(phase),      32'd0);
    chk({tag, " irop"},  32'(ir_opcode),  32'd0);
    chk({tag, " iropd"}, 32'(ir_operand), 32'd0);
    chk({tag, " we"},    32'(ram_we),     32'd0);
    chk({tag, " re"},    32'(ram_re),     32'd0);
  endtask

  initial begin
    //   op   opd  lo     in  acc c  z  pc      out sp
    add('h4, 'h7, 'h00, 0, 'h7, 0, 0, 'h001, 0, 0, "LIT7");
    add('hA, 'hA, 'h00, 0, 'h1, 1, 0, 'h002, 0, 0, "ADDI_A");
    add('hA, 'hF, 'h00, 0, 'h0, 1, 1, 'h003, 0, 0, "ADDI_F");
    add('h4, 'h5, 'h00, 0, 'h5, 1, 0, 'h004, 0, 0, "LIT5");
    add('h7, 'h1, 'h23, 0, 'h5, 1, 0, 'h006, 0, 0, "ST123");
    add('h4, 'h0, 'h00, 0, 'h0, 1, 1, 'h007, 0, 0, "LIT0");
    add('h6, 'h1, 'h23, 0, 'h5, 1, 0, 'h009, 0, 0, "LD123");
    add('h4, 'h3, 'h00, 0, 'h3, 1, 0, 'h00A, 0, 0, "LIT3");
    add('h2, 'h5, 'h00, 0, 'h3, 1, 0, 'h00B, 0, 0, "CMPI5");
    add('h0, 'h0, 'h40, 0, 'h3, 1, 0, 'h040, 0, 0, "JC040");
    add('h8, 'h0, 'h80, 0, 'h3, 1, 0, 'h042, 0, 0, "JZ080_nt");
    add('h5, 'h0, 'h00, 9, 'h9, 1, 0, 'h043, 0, 0, "IN9");
    add('h2, 'h9, 'h00, 0, 'h9, 0, 1, 'h044, 0, 0, "CMPI9");
    add('h9, 'h3, 'h00, 0, 'h9, 0, 1, 'h046, 0, 0, "JNZ_nt");
    add('h8, 'h3, 'h00, 0, 'h9, 0, 1, 'h300, 0, 0, "JZ300");
    add('hD, 'h0, 'h00, 0, 'h9, 0, 1, 'h301, 9, 0, "OUT");
    add('h4, 'hC, 'h00, 0, 'hC, 0, 0, 'h302, 9, 0, "LITC");
    add('h7, 'h0, 'hF0, 0, 'hC, 0, 0, 'h304, 9, 0, "ST0F0");
    add('h4, 'h9, 'h00, 0, 'h9, 0, 0, 'h305, 9, 0, "LIT9");
    add('h3, 'h0, 'hF0, 0, 'h9, 1, 0, 'h307, 9, 0, "CMPM");
    add('hB, 'h0, 'hF0, 0, 'h5, 1, 0, 'h309, 9, 0, "ADDM");
    add('h1, 'h5, 'h00, 0, 'h5, 1, 0, 'h30B, 9, 0, "JNC_nt");
    add('hC, 'hF, 'hFE, 0, 'h5, 1, 0, 'hFFE, 9, 0, "JMPFFE");
    add('h4, 'h0, 'h00, 0, 'h0, 1, 1, 'hFFF, 9, 0, "LIT0_top");
    add('h4, 'h2, 'h00, 0, 'h2, 1, 0, 'h000, 9, 0, "LIT2_wrap");
    add('h2, 'h1, 'h00, 0, 'h2, 0, 0, 'h001, 9, 0, "CMPI1");
    add('h1, 'h0, 'h10, 0, 'h2, 0, 0, 'h010, 9, 0, "JNC010");
`ifdef ACC_CORE_CALL_EN
    add('hE, 'h2, 'h00, 0, 'h2, 0, 0, 'h200, 9, 1, "CALL200");
    add('hF, 'h0, 'h00, 0, 'h2, 0, 0, 'h012, 9, 0, "RET");
    add('hA, 'hE, 'h00, 0, 'h0, 1, 1, 'h013, 9, 0, "ADDI_E");
`else
    add('hE, 'h2, 'h00, 0, 'h2, 0, 0, 'h012, 9, 0, "CALL_nop");
    add('hF, 'h0, 'h00, 0, 'h2, 0, 0, 'h013, 9, 0, "RET_nop");
    add('hA, 'hE, 'h00, 0, 'h0, 1, 1, 'h014, 9, 0, "ADDI_E");
`endif

    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    in_port = 4'h0;
    rst = 1'b1;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cur_pc = 12'h000;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Store/load strobes: one write cycle per ST, one read cycle per LD/CMPM/ADDM.
    chk("we_count",   32'(we_cnt),        32'd2);
    chk("we_addr",    32'(we_addr),       32'h123);
    chk("we_data",    32'(we_data),       32'h5);
    chk("re_count",   32'(re_cnt),        32'd3);
    chk("ram123",     32'(ram[12'h123]),  32'h5);
    chk("ram0F0",     32'(ram[12'h0F0]),  32'hC);

    // Reset in the middle of an ST EXEC: strobe drops at once, nothing written.
    rom[cur_pc]         = 8'h71;
    rom[cur_pc + 12'd1] = 8'h23;
    step();
    chk("abort we_hi",   32'(ram_we),    32'd1);
    chk("abort addr",    32'(ram_addr),  32'h123);
    chk("abort wdata",   32'(ram_wdata), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort we_lo",   32'(ram_we),    32'd0);
    chk("abort phase",   32'(phase),     32'd0);
    step();
    chk("abort ram123",  32'(ram[12'h123]), 32'h5);
    chk_zero("abort");
    rst = 1'b0;
    cur_pc = 12'h000;

`ifdef ACC_CORE_CALL_EN
    // Five nested CALLs on a 4-deep stack: the fifth faults and freezes pc.
    for (int i = 0; i < 5; i++) begin
      rom[cur_pc]         = 8'hE0;
      rom[cur_pc + 12'd1] = 8'(cur_pc + 12'h010);
      step();
      step();
      if (i < 4) begin
        chk($sformatf("call%0d pc", i),    32'(pc),    32'(cur_pc + 12'h010));
        chk($sformatf("call%0d sp", i),    32'(sp),    32'(i + 1));
        chk($sformatf("call%0d fault", i), 32'(fault), 32'd0);
        cur_pc = cur_pc + 12'h010;
      end else begin
        chk("ovf fault", 32'(fault), 32'd1);
        chk("ovf pc",    32'(pc),    32'h041);
        chk("ovf sp",    32'(sp),    32'd4);
        chk("ovf phase", 32'(phase), 32'd0);
      end
    end
    repeat (3) step();
    chk("frozen pc",    32'(pc),     32'h041);
    chk("frozen fault", 32'(fault),  32'd1);
    chk("frozen phase", 32'(phase),  32'd0);
    chk("frozen we",    32'(ram_we), 32'd0);
    rst = 1'b1;
    #1;
    chk_zero("fault_rst");
    step();
    rst = 1'b0;

    // RET with an empty stack faults.
    rom[12'h000] = 8'hF0;
    step();
    step();
    chk("unf fault", 32'(fault), 32'd1);
    chk("unf pc",    32'(pc),    32'h001);
    chk("unf sp",    32'(sp),    32'd0);
    repeat (2) step();
    chk("unf frozen pc", 32'(pc), 32'h001);
`else
    // Without the stack, CALL/RET never disturb sp or fault.
    rom[12'h000] = 8'hF0;
    step();
    step();
    chk("nop ret fault", 32'(fault), 32'd0);
    chk("nop ret pc",    32'(pc),    32'h001);
    chk("nop ret sp",    32'(sp),    32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_core_p.md
# acc_core_p

Parametrised two-phase accumulator processor core with C/Z flags, external program and data memory ports, an input port and a registered output port. Adds a hardware return-address stack for CALL/RET with overflow/underflow fault detection. It is the generalised successor of the team's fixed 4-bit core and replaces it at the top level of the lab designs. Program ROM and data RAM sit outside the block.

## Interface
- DW, 4: data/accumulator/operand width; instruction word IW = 4+DW; address width AW = 2*DW+4 (localparams)
- STACK_DEPTH, 4: return-stack entries (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rom_addr  out  AW  program address (= pc)
- rom_data  in  IW  program word, combinational read of rom_addr
- ram_addr  out  AW  data address = {ir_operand, rom_data}
- ram_rdata  in  DW  data read, combinational
- ram_wdata  out  DW  = acc
- ram_we  out  1  write strobe
- ram_re  out  1  read strobe
- in_port  in  DW  input switches
- out_port  out  DW  registered output
- pc  out  AW  program counter
- ir_opcode  out  4  latched opcode
- ir_operand  out  DW  latched operand
- acc  out  DW  accumulator
- c_flag, z_flag  out  1  flags
- phase  out  1  0 = FETCH, 1 = EXEC
- fault  out  1  stack fault, sticky
- sp  out  clog2(STACK_DEPTH+1)  stack entry count

## Operation
- States: FETCH → EXEC → FETCH; FAULT absorbing until rst.
- FETCH: {ir_opcode, ir_operand} ← rom_data; pc ← pc+1.
- EXEC, one-word ops (pc unchanged): 0x2 CMPI n, 0x4 LIT n, 0x5 IN, 0xA ADDI n, 0xD OUT, 0xF RET.
- EXEC, two-word ops (rom_data = address low word, target T = {ir_operand, rom_data}): 0x0 JC, 0x1 JNC, 0x8 JZ, 0x9 JNZ, 0xC JMP, 0xE CALL, 0x3 CMPM, 0x6 LD, 0x7 ST, 0xB ADDM. Taken jump: pc ← T; otherwise pc ← pc+1.
- LIT: acc ← n. IN: acc ← in_port. LD: acc ← ram_rdata. These update Z = (acc_new==0); C unchanged.
- ADDI/ADDM: {C, acc} ← acc + operand, DW+1-bit sum; Z = (acc_new==0).
- CMPI/CMPM: compute acc − operand in DW+1 bits, acc unchanged; C = borrow (acc < operand unsigned), Z = (acc == operand).
- ST: ram_we=1 for the EXEC cycle only, ram_wdata = acc. LD/CMPM/ADDM: ram_re=1 for the EXEC cycle only. Both strobes 0 otherwise.
- OUT: out_port ← acc. Flags unchanged.
- CALL: push pc+1 (return address), sp+1, pc ← T. CALL with sp==STACK_DEPTH: no push, pc held, fault ← 1, state ← FAULT.
- RET: pc ← top entry, sp−1. RET with sp==0: fault ← 1, state ← FAULT.
- FAULT: no register changes, strobes 0, phase 0, pc frozen.
- pc wraps from 2^AW−1 to 0 silently.

## Timing
- Reset: pc, ir_*, acc, flags, out_port, sp, fault, phase all 0; state FETCH; stack contents undefined.
- Each instruction takes exactly 2 cycles; all state updates occur on the rising clk edge that ends EXEC.
- ram_addr and strobes are combinational from EXEC state, ir and rom_data; RAM must return data within the EXEC cycle.
- rst mid-EXEC aborts the instruction: no write is committed; ram_we falls asynchronously.
- fault rises on the edge ending the faulting EXEC and stays high until rst.

## Configuration
- ACC_CORE_CALL_EN defined: return stack, CALL/RET and fault logic as above.
- Not defined: no stack storage; 0xE executes as a two-word NOP (pc ← pc+1); 0xF is a one-word NOP; fault and sp are tied to 0.

## Test plan
- DW=4. LIT 7; ADDI 0xA → acc=1, C=1, Z=0. Then ADDI 0xF → acc=0, C=1, Z=1. Both execute in 2 cycles each.
- LIT 5; ST 0x123; LIT 0; LD 0x123 → ram_we pulses 1 cycle with addr 0x123 and wdata 5; acc=5, Z=0.
- LIT 3; CMPI 5 → C=1, Z=0, acc=3. JC 0x040 → pc=0x040. JZ 0x080 → pc falls through (+1).
- CALL 0x200 at pc=0x010 → sp=1, pc=0x200. RET → pc=0x012, sp=0.
- With STACK_DEPTH=4, 5 nested CALLs → fault=1 and pc frozen; assert rst → all outputs 0. Separately, RET at sp=0 → fault=1.
- Without ACC_CORE_CALL_EN: CALL 0x200 at pc=0x010 → pc=0x012, sp=0, fault=0.
